// File: rtl/m3_key_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : m3_key_cmd_decoder
// Brief   : Motor-3 front-panel key synchroniser, debouncer and start/stop/
//           reverse command FSM. Optional auto-reverse via M3_AUTO_REVERSE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module m3_key_cmd_decoder #(
    parameter int DEBOUNCE_N  = 3,
    parameter int STOP_HOLD_N = 50
) (
    input  logic clkI,
    input  logic rstI,
    input  logic tick100hzI,
    input  logic keyStartN,
    input  logic keyStopN,
    input  logic keyInvN,
    input  logic keySpdUpN,
    input  logic keySpdDnN,
    input  logic keyPwrUpN,
    input  logic keyPwrDnN,
    output logic m3startO,
    output logic m3forceStopO,
    output logic m3invRotateO,
    output logic m3speedINCo,
    output logic m3speedDECo,
    output logic m3powerINCo,
    output logic m3powerDECo
);

    localparam int         c_NUM_KEYS = 7;
    localparam int         c_K_START  = 0;
    localparam int         c_K_STOP   = 1;
    localparam int         c_K_INV    = 2;
    localparam int         c_K_SPDUP  = 3;
    localparam int         c_K_SPDDN  = 4;
    localparam int         c_K_PWRUP  = 5;
    localparam int         c_K_PWRDN  = 6;
    localparam logic [3:0] c_DB_N     = 4'(DEBOUNCE_N);
    localparam logic [7:0] c_HOLD_N   = 8'(STOP_HOLD_N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2,
        S_REV  = 2'd3
    } state_t;

    logic [c_NUM_KEYS-1:0] w_rawPressed;
    logic [c_NUM_KEYS-1:0] r_sync1;
    logic [c_NUM_KEYS-1:0] r_sync2;
    logic [3:0]            r_dbCnt [c_NUM_KEYS];
    logic [c_NUM_KEYS-1:0] r_dbKey;
    logic [c_NUM_KEYS-1:0] r_dbKeyD;
    logic [c_NUM_KEYS-1:0] w_press;

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_holdCnt;
    logic [7:0] w_nextHold;
    logic       r_inv;
    logic       w_nextInv;
    logic       w_nextRun;
`ifdef M3_AUTO_REVERSE_EN
    logic       r_pending;
    logic       w_nextPending;
`endif

    // Inverting ahead of the synchroniser makes the reset value (0) mean "released".
    assign w_rawPressed = ~{keyPwrDnN, keyPwrUpN, keySpdDnN, keySpdUpN,
                            keyInvN, keyStopN, keyStartN};

    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_rawPressed;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            r_dbKey  <= '0;
            r_dbKeyD <= '0;
            for (int k = 0; k < c_NUM_KEYS; k++) begin
                r_dbCnt[k] <= '0;
            end
        end else begin
            r_dbKeyD <= r_dbKey;
            if (tick100hzI) begin
                for (int k = 0; k < c_NUM_KEYS; k++) begin
                    if (r_sync2[k] == r_dbKey[k]) begin
                        r_dbCnt[k] <= '0;
                    end else if (r_dbCnt[k] + 4'd1 == c_DB_N) begin
                        r_dbKey[k] <= ~r_dbKey[k];
                        r_dbCnt[k] <= '0;
                    end else begin
                        r_dbCnt[k] <= r_dbCnt[k] + 4'd1;
                    end
                end
            end
        end
    end

    assign w_press = r_dbKey & ~r_dbKeyD;

    always_comb begin
        w_nextState = r_state;
        w_nextHold  = r_holdCnt;
        w_nextInv   = r_inv;
`ifdef M3_AUTO_REVERSE_EN
        w_nextPending = r_pending;
`endif
        case (r_state)
            S_IDLE: begin
                // A stop press in idle does nothing but still masks inv/start.
                if (!w_press[c_K_STOP]) begin
                    if (w_press[c_K_INV]) begin
                        w_nextInv = ~r_inv;
                    end else if (w_press[c_K_START]) begin
                        w_nextState = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_press[c_K_STOP]) begin
                    w_nextState = S_STOP;
                    w_nextHold  = c_HOLD_N;
`ifdef M3_AUTO_REVERSE_EN
                end else if (w_press[c_K_INV]) begin
                    w_nextState   = S_STOP;
                    w_nextHold    = c_HOLD_N;
                    w_nextPending = 1'b1;
`endif
                end
            end
            S_STOP: begin
`ifdef M3_AUTO_REVERSE_EN
                if (w_press[c_K_STOP]) begin
                    w_nextPending = 1'b0;
                end
`endif
                if (tick100hzI) begin
                    w_nextHold = r_holdCnt - 8'd1;
                    if (r_holdCnt == 8'd1) begin
`ifdef M3_AUTO_REVERSE_EN
                        w_nextState = w_nextPending ? S_REV : S_IDLE;
`else
                        w_nextState = S_IDLE;
`endif
                    end
                end
            end
`ifdef M3_AUTO_REVERSE_EN
            S_REV: begin
                w_nextInv     = ~r_inv;
                w_nextPending = 1'b0;
                w_nextState   = S_RUN;
            end
`endif
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign w_nextRun = (w_nextState == S_RUN);

    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            r_state      <= S_IDLE;
            r_holdCnt    <= '0;
            r_inv        <= 1'b0;
            m3startO     <= 1'b0;
            m3forceStopO <= 1'b0;
            m3speedINCo  <= 1'b0;
            m3speedDECo  <= 1'b0;
            m3powerINCo  <= 1'b0;
            m3powerDECo  <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_holdCnt    <= w_nextHold;
            r_inv        <= w_nextInv;
            m3startO     <= w_nextRun;
            m3forceStopO <= (w_nextState == S_STOP);
            m3speedINCo  <= w_nextRun & r_dbKey[c_K_SPDUP] & ~r_dbKey[c_K_SPDDN];
            m3speedDECo  <= w_nextRun & r_dbKey[c_K_SPDDN] & ~r_dbKey[c_K_SPDUP];
            m3powerINCo  <= w_nextRun & r_dbKey[c_K_PWRUP] & ~r_dbKey[c_K_PWRDN];
            m3powerDECo  <= w_nextRun & r_dbKey[c_K_PWRDN] & ~r_dbKey[c_K_PWRUP];
        end
    end

`ifdef M3_AUTO_REVERSE_EN
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_nextPending;
        end
    end
`endif

    assign m3invRotateO = r_inv;

endmodule
`default_nettype wire
